// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: per-register in-flight writer counters with ID issue interlock.
// Optional macro RF_SB_WB_BYPASS_EN lets a consumer issue in the retire cycle of its last producer.
module rf_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       id_valid,
  input  logic       id_rs1_en,
  input  logic       id_rs2_en,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_gr_we,
  input  logic [4:0] id_dest,
  input  logic       ex_allowin,
  output logic       id_ready_go,
  input  logic       wb_rf_we,
  input  logic [4:0] wb_rf_waddr,
  input  logic       flush,
  output logic       sb_busy,
  output logic       sb_err
);

  logic [CNT_W-1:0] cnt      [1:31];
  logic [CNT_W-1:0] cnt_view [0:31];
  logic             rs1_haz;
  logic             rs2_haz;
  logic             ovf_haz;
  logic             issue;
  logic             retire;
  logic             err_q;

  // Register 0 is presented as a constant zero so lookups need no special case.
  always_comb begin
    cnt_view[0] = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      cnt_view[i] = cnt[i];
    end
  end

  assign retire = wb_rf_we && (wb_rf_waddr != 5'd0) && !flush;

  always_comb begin
    rs1_haz = id_rs1_en && (cnt_view[id_rs1] != '0);
    rs2_haz = id_rs2_en && (cnt_view[id_rs2] != '0);
`ifdef RF_SB_WB_BYPASS_EN
    // Last outstanding writer retiring now: the RF write-before-read bypass supplies the value.
    if (retire && (wb_rf_waddr == id_rs1) && (cnt_view[id_rs1] == CNT_W'(1))) rs1_haz = 1'b0;
    if (retire && (wb_rf_waddr == id_rs2) && (cnt_view[id_rs2] == CNT_W'(1))) rs2_haz = 1'b0;
`endif
    ovf_haz = id_gr_we && (id_dest != 5'd0) && (cnt_view[id_dest] == '1);
  end

  assign id_ready_go = !rs1_haz && !rs2_haz && !ovf_haz;

  assign issue = id_valid && id_ready_go && ex_allowin && id_gr_we &&
                 (id_dest != 5'd0) && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 1; i < 32; i++) begin
        cnt[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 1; i < 32; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        if (issue && (id_dest == 5'(i)) && !(retire && (wb_rf_waddr == 5'(i)))) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (retire && (wb_rf_waddr == 5'(i)) && !(issue && (id_dest == 5'(i)))) begin
          if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (retire && (cnt_view[wb_rf_waddr] == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign sb_err = err_q;

  always_comb begin
    sb_busy = 1'b0;
    for (int unsigned i = 1; i < 32; i++) begin
      sb_busy = sb_busy | (cnt[i] != '0);
    end
  end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-file scoreboard and issue interlock for the five-stage pipeline. It counts in-flight writers per architectural register between the ID issue point and the WB register-file write, and holds ID when a source or destination hazard exists. It sequences ID-to-EX issue against WB retirement of the shared register-file write port, and sits beside ID, fed by ID decode and the WB `rf_we`/`rf_waddr` outputs.

## Interface
- `CNT_W`, default 2: width of each per-register pending counter; the maximum in-flight writers per register is 2^CNT_W − 1.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_rs1_en`, `id_rs2_en`  in  1 each  source operand actually read.
- `id_rs1`, `id_rs2`  in  5 each  source register numbers.
- `id_gr_we`  in  1  instruction writes a GPR.
- `id_dest`  in  5  destination register.
- `ex_allowin`  in  1  EX can accept an instruction this cycle.
- `id_ready_go`  out  1  no hazard; ID may issue.
- `wb_rf_we`  in  1  WB commits a register write this cycle.
- `wb_rf_waddr`  in  5  WB write address.
- `flush`  in  1  pipeline flush; discards all in-flight writers.
- `sb_busy`  out  1  at least one counter is non-zero.
- `sb_err`  out  1  sticky flag: retire seen with a zero counter.

## Operation
- State: 31 counters `cnt[1..31]`, each CNT_W bits. Register 0 is never tracked. Its counter reads as 0 and it is ignored as a source or destination.
- Source hazard: `id_rsN_en` is set, `id_rsN` ≠ 0, and `cnt[id_rsN]` ≠ 0.
- Overflow hazard: `id_gr_we` is set, `id_dest` ≠ 0, and `cnt[id_dest]` is all-ones.
- `id_ready_go` is high when there is no source hazard and no overflow hazard. It is combinational from the counters and the ID inputs.
- Issue event: `id_valid & id_ready_go & ex_allowin & id_gr_we & (id_dest≠0) & ~flush`. It increments `cnt[id_dest]`.
- Retire event: `wb_rf_we & (wb_rf_waddr≠0) & ~flush`. It decrements `cnt[wb_rf_waddr]`.
- Issue and retire to the same register in one cycle: the counter is unchanged.
- Issue and retire to different registers in one cycle: both updates apply.
- Retire when the counter is 0: the counter stays 0, and `sb_err` sets and stays set until reset.
- `flush` high: all counters clear to 0 at that edge; issue and retire in the same cycle are discarded. `sb_err` is unaffected.
- `sb_busy` is the OR of all counters.

## Timing
- Reset values: all counters 0, `sb_err`=0, `sb_busy`=0. With no ID sources enabled, `id_ready_go`=1.
- `resetn` low mid-operation clears state immediately, independent of `clk`.
- Issue latency: the counter increments at the issuing edge. A dependent instruction stalls from the following cycle.
- Retire latency: the counter decrements at the WB edge. A stalled consumer sees `id_ready_go`=1 in the next cycle (default build).
- No handshake of its own: `id_ready_go` feeds the ID `ready_go` term. The ID→EX transfer fires exactly when the issue condition above holds.

## Configuration
- `RF_SB_WB_BYPASS_EN` defined:
  - A source hazard is suppressed when the same cycle's retire targets that source register and its counter equals 1.
  - The consumer issues in the retire cycle.
  - This relies on the register file's write-before-read bypass.
- `RF_SB_WB_BYPASS_EN` undefined: the consumer stalls through the retire cycle and issues one cycle later.
- The overflow hazard is never bypassed in either build.

## Test plan
- Reset, then ID reads r5 with all counters 0 → `id_ready_go`=1, `sb_busy`=0, `sb_err`=0.
- Issue a write to r3 in cycle 0, then ID reads r3 in cycle 1 → `id_ready_go`=0. Assert `wb_rf_we`/`wb_rf_waddr`=3 in cycle 3:
  - Default build: `id_ready_go`=1 in cycle 4.
  - `RF_SB_WB_BYPASS_EN` build: `id_ready_go`=1 in cycle 3.
- With CNT_W=2, issue three back-to-back writes to r7 → `cnt[7]`=3. A fourth r7 writer sees `id_ready_go`=0 until one r7 retire.
- In one cycle, issue to r4 and retire r4 with `cnt[4]`=1 → `cnt[4]` remains 1 and `sb_busy` stays 1.
- Counters r1=1, r2=2, then `flush` high for one cycle together with an issue to r9 → all counters 0 and `sb_busy`=0 next cycle, with no r9 entry.
- Retire r10 with `cnt[10]`=0 → `cnt[10]` stays 0 and `sb_err`=1, held until `resetn` goes low. An issue to r0 leaves all counters unchanged.
